// File: rtl/textcon_if.sv
`default_nettype none
// ============================================================================
// Module   : textcon_if
// Desc     : Byte-stream input and tram system-side write port of textcon.
// Revision : 1.0 - initial release
// ============================================================================
interface textcon_if #(
    parameter int WORD     = 32,
    parameter int BYTE_CNT = 4,
    parameter int ADDRW    = 11
) ();
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic [BYTE_CNT-1:0] we_sys;
    logic [ADDRW-1:0]    addr_sys;
    logic [WORD-1:0]     din_sys;

    // master: the console writer (drives tram writes, accepts bytes)
    modport master (
        input  in_valid, in_data,
        output in_ready, we_sys, addr_sys, din_sys
    );

    // slave: character source plus tram write port
    modport slave (
        output in_valid, in_data,
        input  in_ready, we_sys, addr_sys, din_sys
    );
endinterface
`default_nettype wire

// File: rtl/textcon.sv
`default_nettype none
// ============================================================================
// Module   : textcon
// Desc     : Text console writer: byte stream to tram cells, cursor, ring scroll.
// Revision : 1.0 - initial release
// ============================================================================
module textcon #(
    parameter int WORD     = 32,
    parameter int BYTE_CNT = 4,
    parameter int ADDRW    = 11,
    parameter int ATTRW    = 24
) (
    input  wire logic             clk_sys,
    input  wire logic             rst_sys_n,
    input  wire logic [ADDRW-1:0] text_hres,
    input  wire logic [ADDRW-1:0] text_vres,
    input  wire logic [ATTRW-1:0] attr,
    textcon_if.master             bus,
    output logic      [ADDRW-1:0] scroll_offs,
    output logic      [ADDRW-1:0] cur_col,
    output logic      [ADDRW-1:0] cur_row,
    output logic                  busy
);
    localparam int CNTW = ADDRW + 1;

    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_clear_line = 2'd1;
    localparam logic [1:0] c_st_clear_all  = 2'd2;

    localparam logic [ADDRW-1:0] c_one   = ADDRW'(1);
    localparam logic [7:0]       c_lf    = 8'h0A;
    localparam logic [7:0]       c_cr    = 8'h0D;
    localparam logic [7:0]       c_bs    = 8'h08;
    localparam logic [7:0]       c_ff    = 8'h0C;
    localparam logic [7:0]       c_blank = 8'h20;

    logic [1:0]          r_state;
    logic                r_ready;
    logic [BYTE_CNT-1:0] r_we;
    logic [ADDRW-1:0]    r_addr;
    logic [WORD-1:0]     r_din;
    logic [ADDRW-1:0]    r_scroll;
    logic [ADDRW-1:0]    r_col;
    logic [ADDRW-1:0]    r_row;
    logic [ADDRW-1:0]    r_cur_addr;
    logic [ADDRW-1:0]    r_line_addr;
    logic [ADDRW-1:0]    r_clr_addr;
    logic [CNTW-1:0]     r_clr_cnt;

    // (a + b) mod depth for operands already below depth
    function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] a,
                                                  input logic [ADDRW-1:0] b,
                                                  input logic [CNTW-1:0]  depth);
        logic [CNTW-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= depth)
            s = s - depth;
        return s[ADDRW-1:0];
    endfunction

    logic [CNTW-1:0]  w_depth;
    logic [7:0]       w_code;
    logic             w_accept;
    logic             w_is_print;
    logic [ADDRW-1:0] w_col_inc;
    logic             w_do_nl;
    logic             w_last_row;
    logic [ADDRW-1:0] w_next_line;
    logic [ADDRW-1:0] w_next_cell;
    logic [ADDRW-1:0] w_prev_cell;
    logic [ADDRW-1:0] w_scroll_next;

    assign w_depth       = CNTW'(text_hres) * CNTW'(text_vres);
    assign w_code        = bus.in_data;
    assign w_accept      = bus.in_valid && r_ready && (r_state == c_st_idle);
    assign w_is_print    = (w_code >= 8'h20) && (w_code != 8'h7F);
    assign w_col_inc     = r_col + c_one;
    assign w_do_nl       = (w_code == c_lf) || (w_is_print && (w_col_inc == text_hres));
    assign w_last_row    = (r_row == (text_vres - c_one));
    assign w_next_line   = wrap_add(r_line_addr, text_hres, w_depth);
    assign w_next_cell   = wrap_add(r_cur_addr, c_one, w_depth);
    assign w_prev_cell   = (r_cur_addr == '0) ? (w_depth[ADDRW-1:0] - c_one)
                                              : (r_cur_addr - c_one);
    assign w_scroll_next = wrap_add(r_scroll, text_hres, w_depth);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state     <= c_st_idle;
            r_ready     <= 1'b0;
            r_we        <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_scroll    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_cur_addr  <= '0;
            r_line_addr <= '0;
            r_clr_addr  <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_we <= '0;
            case (r_state)
                c_st_idle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_is_print) begin
                            r_we   <= '1;
                            r_addr <= r_cur_addr;
                            r_din  <= {attr, w_code};
                        end
                        if (w_do_nl) begin
                            r_col <= '0;
                            if (!w_last_row) begin
                                r_row       <= r_row + c_one;
                                r_line_addr <= w_next_line;
                                r_cur_addr  <= w_next_line;
                            end else begin
                                // Old top line becomes the new bottom line of the ring.
                                r_line_addr <= r_scroll;
                                r_cur_addr  <= r_scroll;
                                r_clr_addr  <= r_scroll;
                                r_scroll    <= w_scroll_next;
                                r_clr_cnt   <= CNTW'(text_hres);
                                r_state     <= c_st_clear_line;
                                r_ready     <= 1'b0;
                            end
                        end else if (w_is_print) begin
                            r_col      <= w_col_inc;
                            r_cur_addr <= w_next_cell;
                        end else if (w_code == c_cr) begin
                            r_col      <= '0;
                            r_cur_addr <= r_line_addr;
                        end else if ((w_code == c_bs) && (r_col != '0)) begin
                            r_col      <= r_col - c_one;
                            r_cur_addr <= w_prev_cell;
                        end else if (w_code == c_ff) begin
                            r_scroll    <= '0;
                            r_col       <= '0;
                            r_row       <= '0;
                            r_cur_addr  <= '0;
                            r_line_addr <= '0;
                            r_clr_addr  <= '0;
                            r_clr_cnt   <= w_depth;
                            r_state     <= c_st_clear_all;
                            r_ready     <= 1'b0;
                        end
                    end
                end
                c_st_clear_line, c_st_clear_all: begin
                    r_we       <= '1;
                    r_addr     <= r_clr_addr;
                    r_din      <= {attr, c_blank};
                    r_clr_addr <= wrap_add(r_clr_addr, c_one, w_depth);
                    r_clr_cnt  <= r_clr_cnt - CNTW'(1);
                    if (r_clr_cnt == CNTW'(1)) begin
                        r_state <= c_st_idle;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.we_sys   = r_we;
    assign bus.addr_sys = r_addr;
    assign bus.din_sys  = r_din;
    assign scroll_offs  = r_scroll;
    assign cur_col      = r_col;
    assign cur_row      = r_row;
    assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_textcon.sv
`default_nettype none
// ============================================================================
// Module   : tb_textcon
// Desc     : Self-checking bench for textcon: vector table, scroll/clear
//            sequences and random bytes against a screen-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_textcon;
    localparam int WORD     = 32;
    localparam int BYTE_CNT = 4;
    localparam int ADDRW    = 11;
    localparam int ATTRW    = 24;

    logic             clk_sys = 1'b0;
    logic             rst_sys_n;
    logic [ADDRW-1:0] text_hres;
    logic [ADDRW-1:0] text_vres;
    logic [ATTRW-1:0] attr;
    logic [ADDRW-1:0] scroll_offs;
    logic [ADDRW-1:0] cur_col;
    logic [ADDRW-1:0] cur_row;
    logic             busy;

    always #5 clk_sys = ~clk_sys;

    textcon_if #(.WORD(WORD), .BYTE_CNT(BYTE_CNT), .ADDRW(ADDRW)) bus ();

    textcon #(.WORD(WORD), .BYTE_CNT(BYTE_CNT), .ADDRW(ADDRW), .ATTRW(ATTRW)) dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .text_hres  (text_hres),
        .text_vres  (text_vres),
        .attr       (attr),
        .bus        (bus),
        .scroll_offs(scroll_offs),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- screen-level reference model ----------------
    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [WORD-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    bit  model_en  = 1'b0;
    int  exp_stall = 0;
    int  m_col = 0, m_row = 0, m_scroll = 0;

    task automatic push_wr(input int a, input logic [7:0] c);
        wr_t w;
        w.addr = ADDRW'(a);
        w.data = {attr, c};
        exp_q.push_back(w);
    endtask

    // Physical cell = (scroll + row*hres + col) mod depth, computed directly.
    task automatic model_newline();
        int h = int'(text_hres);
        int d = int'(text_hres) * int'(text_vres);
        if (m_row < int'(text_vres) - 1) begin
            m_row++;
        end else begin
            m_scroll = (m_scroll + h) % d;
            for (int k = 0; k < h; k++)
                push_wr((m_scroll + m_row * h + k) % d, 8'h20);
            exp_stall = h;
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        int h = int'(text_hres);
        int d = int'(text_hres) * int'(text_vres);
        if (c >= 8'h20 && c != 8'h7F) begin
            push_wr((m_scroll + m_row * h + m_col) % d, c);
            m_col++;
            if (m_col == h) begin
                m_col = 0;
                model_newline();
            end
        end else begin
            case (c)
                8'h0A: begin m_col = 0; model_newline(); end
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) m_col--;
                8'h0C: begin
                    m_scroll = 0; m_col = 0; m_row = 0;
                    for (int k = 0; k < d; k++) push_wr(k, 8'h20);
                    exp_stall = d;
                end
                default: ;
            endcase
        end
    endtask

    // Write scoreboard: every tram write must match the model's next write.
    always @(negedge clk_sys) begin : mon
        wr_t w;
        if (model_en && rst_sys_n === 1'b1 && bus.we_sys !== '0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, required no write (t=%0t)",
                         bus.addr_sys, bus.din_sys, $time);
            end else begin
                w = exp_q.pop_front();
                chk("wr_en",   bus.we_sys,   {BYTE_CNT{1'b1}});
                chk("wr_addr", bus.addr_sys, w.addr);
                chk("wr_data", bus.din_sys,  w.data);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        @(negedge clk_sys);
        bus.in_valid = 1'b0;
        while (!bus.in_ready && n < 5000) begin
            n++;
            @(negedge clk_sys);
        end
        if (model_en) begin
            chk("ready_low_cycles", n, exp_stall);
            exp_stall = 0;
        end
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        @(posedge clk_sys);
        if (model_en) model_byte(c);
        #1;
        if (model_en) begin
            chk("cur_col",     cur_col,     m_col);
            chk("cur_row",     cur_row,     m_row);
            chk("scroll_offs", scroll_offs, m_scroll);
            chk("busy",        busy,        exp_stall != 0);
        end
    endtask

    task automatic check_drained();
        @(negedge clk_sys);
        #1;
        chk("writes_pending", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] gen(input bit allow_ff);
        int r = $urandom_range(0, 99);
        logic [7:0] v;
        if (r < 65) begin
            v = 8'($urandom_range(32, 255));
            if (v == 8'h7F) v = 8'h7E;
        end else if (r < 80) v = 8'h0A;
        else if (r < 86)     v = 8'h0D;
        else if (r < 93)     v = 8'h08;
        else if (allow_ff && r >= 98) v = 8'h0C;
        else begin
            v = 8'($urandom_range(0, 31));
            if (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D) v = 8'h7F;
        end
        return v;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] code;
        int         col;
        int         row;
        bit         wr;
        int         addr;
    } vec_t;

    vec_t tbl[17];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $finish;
    end

    initial begin
        tbl[0]  = '{8'h41, 1, 0, 1'b1, 0};
        tbl[1]  = '{8'h42, 2, 0, 1'b1, 1};
        tbl[2]  = '{8'h0D, 0, 0, 1'b0, 0};
        tbl[3]  = '{8'h08, 0, 0, 1'b0, 0};
        tbl[4]  = '{8'h07, 0, 0, 1'b0, 0};
        tbl[5]  = '{8'h00, 0, 0, 1'b0, 0};
        tbl[6]  = '{8'h7F, 0, 0, 1'b0, 0};
        tbl[7]  = '{8'h43, 1, 0, 1'b1, 0};
        tbl[8]  = '{8'h80, 2, 0, 1'b1, 1};
        tbl[9]  = '{8'hFF, 3, 0, 1'b1, 2};
        tbl[10] = '{8'h08, 2, 0, 1'b0, 0};
        tbl[11] = '{8'h08, 1, 0, 1'b0, 0};
        tbl[12] = '{8'h44, 2, 0, 1'b1, 1};
        tbl[13] = '{8'h0A, 0, 1, 1'b0, 0};
        tbl[14] = '{8'h45, 1, 1, 1'b1, 84};
        tbl[15] = '{8'h09, 1, 1, 1'b0, 0};
        tbl[16] = '{8'h0D, 0, 1, 1'b0, 0};

        rst_sys_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        text_hres    = 11'd84;
        text_vres    = 11'd24;
        attr         = 24'h00000F;

        // reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_we",       bus.we_sys,   0);
        chk("rst_addr",     bus.addr_sys, 0);
        chk("rst_din",      bus.din_sys,  0);
        chk("rst_scroll",   scroll_offs,  0);
        chk("rst_col",      cur_col,      0);
        chk("rst_row",      cur_row,      0);
        chk("rst_busy",     busy,         0);
        rst_sys_n = 1'b1;
        #1 chk("ready_before_edge", bus.in_ready, 0);
        @(posedge clk_sys);
        #1 chk("ready_after_edge", bus.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            chk("idle_no_write", bus.we_sys, 0);
        end

        // vector table, applied back-to-back
        for (int i = 0; i < 17; i++) begin
            send(tbl[i].code);
            chk("tbl_col",   cur_col,      tbl[i].col);
            chk("tbl_row",   cur_row,      tbl[i].row);
            chk("tbl_ready", bus.in_ready, 1);
            chk("tbl_we",    bus.we_sys,   tbl[i].wr ? 4'hF : 4'h0);
            if (tbl[i].wr) begin
                chk("tbl_addr", bus.addr_sys, tbl[i].addr);
                chk("tbl_data", bus.din_sys,  {24'h00000F, tbl[i].code});
            end
        end
        @(negedge clk_sys);
        bus.in_valid = 1'b0;
        @(negedge clk_sys);
        model_en = 1'b1;

        // clear screen, then fill to the bottom row and scroll once
        send(8'h0C);
        for (int i = 0; i < 24; i++) send(8'h0A);
        chk("scroll_after_24_lf", scroll_offs, 84);
        send(8'h58);
        chk("x_addr", bus.addr_sys, 0);
        chk("x_data", bus.din_sys,  32'h00000F58);
        chk("x_col",  cur_col,      1);
        chk("x_row",  cur_row,      23);

        // a full bottom line wraps into a scroll
        send(8'h0D);
        for (int k = 0; k < 84; k++) begin
            send(8'h61 + 8'(k % 26));
            if (k == 83) begin
                chk("wrap_addr",   bus.addr_sys, 83);
                chk("wrap_data",   bus.din_sys,  32'h00000F66);
                chk("wrap_scroll", scroll_offs,  168);
            end
        end
        for (int i = 0; i < 22; i++) send(8'h0A);
        chk("scroll_wraps_to_0", scroll_offs, 0);
        wait_ready();
        check_drained();

        // random bytes, default geometry
        attr = 24'($urandom);
        for (int i = 0; i < 250; i++) send(gen(1'b0));
        wait_ready();
        check_drained();

        // random bytes, full 2048-cell ring
        text_hres = 11'd64;
        text_vres = 11'd32;
        attr      = 24'($urandom);
        send(8'h0C);
        for (int i = 0; i < 400; i++) send(gen(1'b0));
        wait_ready();
        check_drained();

        // random bytes, tiny screen with form feeds
        text_hres = 11'd7;
        text_vres = 11'd3;
        attr      = 24'($urandom);
        send(8'h0C);
        for (int i = 0; i < 300; i++) send(gen(1'b1));
        wait_ready();
        check_drained();

        // form feed from a scrolled ring, aborted by reset mid-clear
        text_hres = 11'd84;
        text_vres = 11'd24;
        attr      = 24'h00000F;
        send(8'h0C);
        for (int i = 0; i < 25; i++) send(8'h0A);
        chk("scroll_before_ff", scroll_offs, 168);
        send(8'h0C);
        repeat (100) @(negedge clk_sys);
        chk("ff_busy",   busy,         1);
        chk("ff_ready",  bus.in_ready, 0);
        chk("ff_scroll", scroll_offs,  0);
        model_en = 1'b0;
        #2 rst_sys_n = 1'b0;
        #1;
        chk("abort_we",     bus.we_sys,   0);
        chk("abort_addr",   bus.addr_sys, 0);
        chk("abort_din",    bus.din_sys,  0);
        chk("abort_busy",   busy,         0);
        chk("abort_ready",  bus.in_ready, 0);
        chk("abort_col",    cur_col,      0);
        chk("abort_row",    cur_row,      0);
        exp_q.delete();
        exp_stall = 0;
        repeat (3) @(negedge clk_sys);
        chk("abort_hold_we", bus.we_sys, 0);
        rst_sys_n = 1'b1;
        @(posedge clk_sys);
        #1 chk("abort_ready_after", bus.in_ready, 1);
        @(negedge clk_sys);
        chk("abort_idle_we", bus.we_sys, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/textcon.md
# textcon

Text console writer for text-mode RAM (tram): consumes a byte stream of character codes through a valid/ready handshake and writes cell words into tram through its system-side write port. Tracks a cursor and interprets basic control codes. Scrolls by rotating tram as a ring buffer and publishes the offset that the text-mode display reader uses. Sits in the system clock domain between a character source (UART, CPU register) and tram's `we_sys`/`addr_sys`/`din_sys` port.

## Interface
- `WORD`, 32: tram word width (bits).
- `BYTE_CNT`, 4: byte write-enable count.
- `ADDRW`, 11: tram address width.
- `ATTRW`, 24: attribute width; cell word = {attr, code}, `ATTRW`+8 = `WORD`.
- `clk_sys`  in  1  system clock.
- `rst_sys_n`  in  1  reset; asynchronous, active-low.
- `text_hres`  in  ADDRW  line width in cells (≥2).
- `text_vres`  in  ADDRW  line count (≥2); `text_hres`×`text_vres` ≤ 2^ADDRW.
- `attr`  in  ATTRW  attribute bits for every written cell.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  character/control code.
- `in_ready`  out  1  byte accepted on edge where `in_valid`&`in_ready`.
- `we_sys`  out  BYTE_CNT  tram write enable (all ones or all zeros).
- `addr_sys`  out  ADDRW  tram write address.
- `din_sys`  out  WORD  tram write data.
- `scroll_offs`  out  ADDRW  physical address of top display line.
- `cur_col`, `cur_row`  out  ADDRW  logical cursor position.
- `busy`  out  1  high in any clear state.

## Operation
- DEPTH = `text_hres`×`text_vres`. Physical address = (`scroll_offs` + row×hres + col) mod DEPTH, kept incrementally in `cur_addr` and `line_addr` (no multiplier); all increments wrap at DEPTH by compare-and-subtract.
- States: IDLE, CLEAR_LINE, CLEAR_ALL. `in_ready` = 1 only in IDLE.
- Accepted byte in IDLE:
  - 0x20–0x7E, 0x80–0xFF: write {attr, code} at `cur_addr`; col+1; if col reaches hres → newline.
  - 0x0A (LF): col=0, newline.
  - 0x0D (CR): col=0, `cur_addr`=`line_addr`.
  - 0x08 (BS): col>0 → col−1, `cur_addr`−1 (wrap below 0 to DEPTH−1); col=0 → no change. No erase.
  - 0x0C (FF): `scroll_offs`=0, cursor (0,0), enter CLEAR_ALL.
  - Other 0x00–0x1F, 0x7F: consumed, no effect.
- Newline: row<vres−1 → row+1, `line_addr` += hres. Row=vres−1 → row unchanged; new line start = old `scroll_offs`; `scroll_offs` += hres (wrap at DEPTH); enter CLEAR_LINE.
- CLEAR_LINE: hres writes of blank {attr, 0x20} at new line start +0..hres−1, then IDLE.
- CLEAR_ALL: DEPTH blank writes at addresses 0..DEPTH−1, then IDLE.
- `text_hres`/`text_vres` are changed only while `busy`=0 and followed by FF; otherwise behaviour undefined.

## Timing
- Reset (async assert): state IDLE, `in_ready`=0, `we_sys`=0, `addr_sys`=0, `din_sys`=0, `scroll_offs`=0, cursor (0,0), `busy`=0. `in_ready` goes to 1 on the first edge after `rst_sys_n` rises.
- `we_sys`/`addr_sys`/`din_sys` registered: a printable accepted on edge E drives the write during cycle E..E+1 (one-cycle pulse); back-to-back accepts give back-to-back writes, one per cycle.
- Control codes other than newline-at-bottom and FF: `in_ready` stays 1; next byte accepted the following cycle.
- Scroll (LF or wrapping printable at bottom row): on acceptance edge the printable write (if any) is issued, `scroll_offs` updates, `in_ready`→0, `busy`→1. Clear writes issue on the next hres edges; `in_ready`=1/`busy`=0 after the edge issuing the last clear. `in_ready` is low for exactly hres cycles.
- FF: `in_ready` is low for exactly DEPTH cycles, same pattern.
- Cursor outputs update on the acceptance edge.
- Reset mid-clear aborts immediately to reset values; partially cleared tram is left as is.

## Test plan
- Reset then idle: all outputs at reset values; `in_ready`=1 one cycle after release; `we_sys`=0 while `in_valid`=0.
- hres=84, vres=24, attr=0x00000F: send "AB" back-to-back → writes addr 0 data 0x00000F41, addr 1 data 0x00000F42 on consecutive cycles; cursor (2,0).
- CR, BS at col 0, then 0x07 → no writes, cursor (0,0), `in_ready` never drops.
- 23 LFs then LF → `scroll_offs`=84, 84 blank writes (0x00000F20) to addr 0..83, `in_ready` low 84 cycles; then 'X' written at addr 0, cursor (1,23).
- 84 printables on row 23 → 84th written at addr 83 (offset 0), then scroll and clear; 24 scrolls return `scroll_offs` to 0.
- FF with `scroll_offs`=168 → `scroll_offs`=0, 2016 writes addr 0..2015, `in_ready` low 2016 cycles; `rst_sys_n` pulsed mid-clear → writes stop same cycle, reset values restored.
